// File: rtl/operand_gather_if.sv
// Handshake bundle between the operand word feeder, the gather block and the adder stage.
// The slave modport is the gather block's view; master is the surrounding environment's view.
interface operand_gather_if #(
    parameter int unsigned W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_cin;
    logic           out_valid;
    logic           out_ready;
    logic [4*W:0]   ins;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ins
    );

    modport master (
        output in_valid,
        output in_data,
        output in_cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ins
    );
endinterface

// File: rtl/operand_gather.sv
// Gathers four serial W-bit operand words plus a carry-in into a registered
// 4*W+1 bit operand slot for the four-operand adder, with a wrapping packet count.
module operand_gather #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    operand_gather_if.slave      bus,
    output logic [1:0]           word_idx_o,
    output logic [CNT_W-1:0]     pkt_cnt_o
);

    localparam int unsigned INS_W = 4*W + 1;

    typedef enum logic [1:0] {
        ST_X = 2'd0,
        ST_Y = 2'd1,
        ST_Z = 2'd2,
        ST_W = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        x_q, x_d;
    logic [W-1:0]        y_q, y_d;
    logic [W-1:0]        z_q, z_d;
    logic [INS_W-1:0]    ins_q, ins_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic                in_ready_c;
    logic                accept_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_X;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ins_q       <= '0;
            out_valid_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ins_q       <= ins_d;
            out_valid_q <= out_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // The last word only stalls when the slot is full and not draining this cycle.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ins_d       = ins_q;
        out_valid_d = out_valid_q;
        pkt_cnt_d   = pkt_cnt_q;

        in_ready_c  = !flush_i && ((state_q != ST_W) || !out_valid_q || bus.out_ready);
        accept_c    = bus.in_valid && in_ready_c;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush_i) begin
            state_d = ST_X;
        end else if (accept_c) begin
            unique case (state_q)
                ST_X: begin
                    x_d     = bus.in_data;
                    state_d = ST_Y;
                end
                ST_Y: begin
                    y_d     = bus.in_data;
                    state_d = ST_Z;
                end
                ST_Z: begin
                    z_d     = bus.in_data;
                    state_d = ST_W;
                end
                ST_W: begin
                    ins_d       = {bus.in_cin, bus.in_data, z_q, y_q, x_q};
                    out_valid_d = 1'b1;
                    pkt_cnt_d   = pkt_cnt_q + CNT_W'(1);
                    state_d     = ST_X;
                end
                default: state_d = ST_X;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.ins       = ins_q;
    assign word_idx_o    = state_q;
    assign pkt_cnt_o     = pkt_cnt_q;

endmodule

// File: tb/tb_operand_gather.sv
// Randomized and directed bench for operand_gather; a queue-based reference model
// predicts packets, and a monitor compares every presented output slot against it.
module tb_operand_gather;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned INS_W = 4*W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush;
    logic [1:0]       word_idx;
    logic [CNT_W-1:0] pkt_cnt;

    operand_gather_if #(.W(W)) bus ();

    operand_gather #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .bus        (bus),
        .word_idx_o (word_idx),
        .pkt_cnt_o  (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words gathered so far, expected packets, slot occupancy, load count.
    logic [W-1:0]     m_words[$];
    logic [INS_W-1:0] exp_q[$];
    logic [INS_W-1:0] last_ins = '0;
    bit               m_ov = 1'b0;
    int unsigned      m_loaded = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, then advance the model.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit cin,
                         input bit ordy, input bit fl);
        bit exp_rdy;
        bit acc;
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = v ? d : W'($urandom);
        bus.in_cin    = cin;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        chk("word_idx", 64'(word_idx), 64'(m_words.size()));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_loaded % (1 << CNT_W)));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        exp_rdy = !fl && (m_words.size() != 3 || !m_ov || ordy);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        if (m_ov && ordy) m_ov = 1'b0;
        if (fl) begin
            m_words.delete();
        end else if (acc) begin
            m_words.push_back(d);
            if (m_words.size() == 4) begin
                exp_q.push_back({cin, m_words[3], m_words[2], m_words[1], m_words[0]});
                m_words.delete();
                m_loaded++;
                m_ov = 1'b1;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    // Async pulse between clock edges; called right after a cycle() returns.
    task automatic do_reset();
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_word_idx", 64'(word_idx), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_ins", 64'(bus.ins), 64'd0);
        #1;
        rst = 1'b0;
        m_words.delete();
        exp_q.delete();
        m_ov     = 1'b0;
        m_loaded = 0;
        last_ins = '0;
    endtask

    // Monitor: any presented slot must match the oldest predicted packet.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ins_unexpected: got %0h expected no packet at %0t", bus.ins, $time);
                end else begin
                    chk("ins", 64'(bus.ins), 64'(exp_q[0]));
                    if (bus.out_ready) last_ins = exp_q.pop_front();
                end
            end else begin
                chk("ins_hold", 64'(bus.ins), 64'(last_ins));
            end
        end
    end

    initial begin
        int unsigned wrap_exp[5];
        idle_inputs();
        #12;
        chk("init_out_valid", 64'(bus.out_valid), 64'd0);
        chk("init_word_idx", 64'(word_idx), 64'd0);
        chk("init_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("init_ins", 64'(bus.ins), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic packet
        cycle(1, 8'h01, 0, 1, 0);
        cycle(1, 8'h02, 1, 1, 0);
        cycle(1, 8'h03, 0, 1, 0);
        cycle(1, 8'h04, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        chk("t1_ins", 64'(bus.ins), 64'(33'h1_04030201));
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Back-pressure: second packet's last word stalls until the slot drains
        cycle(1, 8'h10, 0, 0, 0);
        cycle(1, 8'h20, 0, 0, 0);
        cycle(1, 8'h30, 0, 0, 0);
        cycle(1, 8'h40, 0, 0, 0);
        cycle(1, 8'h50, 0, 0, 0);
        cycle(1, 8'h60, 0, 0, 0);
        cycle(1, 8'h70, 0, 0, 0);
        cycle(1, 8'h80, 1, 0, 0);
        chk("t2_stall_ready", 64'(bus.in_ready), 64'd0);
        chk("t2_stall_idx", 64'(word_idx), 64'd3);
        cycle(1, 8'h80, 1, 1, 0);
        cycle(0, 8'h00, 0, 0, 0);
        chk("t2_ins", 64'(bus.ins), 64'(33'h1_80706050));
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        cycle(0, 8'h00, 0, 1, 0);

        // Flush drops the partial packet and the word offered during flush
        cycle(1, 8'hAA, 0, 1, 0);
        cycle(1, 8'hBB, 0, 1, 0);
        cycle(1, 8'hCC, 0, 1, 1);
        cycle(1, 8'h11, 0, 1, 0);
        chk("t3_idx_after_flush", 64'(word_idx), 64'd0);
        cycle(1, 8'h22, 0, 1, 0);
        cycle(1, 8'h33, 0, 1, 0);
        cycle(1, 8'h44, 0, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        chk("t3_ins", 64'(bus.ins), 64'(33'h0_44332211));

        // Reset mid-packet with an unconsumed output
        cycle(1, 8'h91, 0, 0, 0);
        cycle(1, 8'h92, 0, 0, 0);
        cycle(1, 8'h93, 0, 0, 0);
        cycle(1, 8'h94, 1, 0, 0);
        cycle(1, 8'h95, 0, 0, 0);
        cycle(1, 8'h96, 0, 0, 0);
        do_reset();
        cycle(1, 8'hA1, 0, 0, 0);
        cycle(1, 8'hA2, 0, 0, 0);
        cycle(1, 8'hA3, 0, 0, 0);
        cycle(1, 8'hA4, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        chk("t4_ins", 64'(bus.ins), 64'(33'h1_A4A3A2A1));
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Counter wrap with a 2-bit counter
        do_reset();
        wrap_exp = '{1, 2, 3, 0, 1};
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 4; i++) cycle(1, W'($urandom), 1'($urandom), 1, 0);
            cycle(0, 8'h00, 0, 1, 0);
            chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(wrap_exp[p]));
        end

        // Carry-in taken only from the last word
        cycle(1, 8'h01, 1, 1, 0);
        cycle(1, 8'h02, 1, 1, 0);
        cycle(1, 8'h03, 1, 1, 0);
        cycle(1, 8'h04, 0, 1, 0);
        cycle(0, 8'h00, 1, 1, 0);
        chk("t6_cin0", 64'(bus.ins[4*W]), 64'd0);
        cycle(1, 8'h05, 0, 1, 0);
        cycle(1, 8'h06, 0, 1, 0);
        cycle(1, 8'h07, 0, 1, 0);
        cycle(1, 8'h08, 1, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        chk("t6_cin1", 64'(bus.ins[4*W]), 64'd1);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom % 4) != 0, W'($urandom), 1'($urandom),
                  1'($urandom), ($urandom % 16) == 0);
        end

        // Drain: every predicted packet must have been presented and consumed
        for (int n = 0; n < 4; n++) cycle(0, 8'h00, 0, 1, 0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
